// File: rtl/store_replay_if.sv
// store_replay_if: run/running control, sequence configuration and beat output of store_replay.
interface store_replay_if #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16
);
    logic               running;
    logic               run;
    logic               done;
    logic [DATA_W-1:0]  start0;
    logic [DATA_W-1:0]  incr0;
    logic [LEN_W-1:0]   length0;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  out0;
    logic               out0_valid;
    modport master (output running, run, start0, incr0, length0, delay0,
                    input  done, out0, out0_valid);
    modport slave  (input  running, run, start0, incr0, length0, delay0,
                    output done, out0, out0_valid);
endinterface

// File: rtl/store_replay.sv
// store_replay: after delay0 running cycles, emits out0 = start0 + k*incr0 for k = 0..length0-1.
module store_replay #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16
) (
    input logic            clk,
    input logic            rst,
    store_replay_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    logic [1:0]         state;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  incr;
    logic [LEN_W-1:0]   beats;
    logic [DELAY_W-1:0] dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            incr           <= '0;
            beats          <= '0;
            dly            <= '0;
            bus.out0       <= '0;
            bus.out0_valid <= 1'b0;
            bus.done       <= 1'b1;
        end else if (bus.run) begin
            acc            <= bus.start0;
            incr           <= bus.incr0;
            beats          <= bus.length0;
            dly            <= bus.delay0;
            bus.out0_valid <= 1'b0;
            bus.done       <= 1'b0;
            state          <= (bus.length0 == '0) ? IDLE : (bus.delay0 != '0) ? DELAY : EMIT;
        end else begin
            bus.out0_valid <= 1'b0;
            if (state == IDLE) begin
                bus.done <= 1'b1;
            end else if (bus.running && state == DELAY) begin
                dly <= dly - DELAY_W'(1);
                if (dly == DELAY_W'(1))
                    state <= EMIT;
            end else if (bus.running && state == EMIT) begin
                // out0 holds its last beat once idle; acc wraps modulo 2^DATA_W
                bus.out0       <= acc;
                bus.out0_valid <= 1'b1;
                acc            <= acc + incr;
                beats          <= beats - LEN_W'(1);
                if (beats == LEN_W'(1))
                    state <= IDLE;
            end
        end
    end
endmodule
